// File: rtl/viterbi_survivor_mem.sv
// viterbi_survivor_mem
// Traceback survivor memory for the Viterbi decoder. Decision columns from
// the ACS stage are stored in a circular buffer of TB_DEPTH columns. Once the
// buffer is full, the block traces back from the reported best state and
// emits the input bit of the oldest undecoded column.
//
// Build option: define SURV_FLUSH_EN to build the end-of-frame drain path
// (flush / flush_done). Without it the flush input is ignored, flush_done is
// held at 0, and columns left in the buffer are never emitted.

module viterbi_survivor_mem #(
    parameter int K        = 3,
    parameter int TB_DEPTH = 16,
    localparam int NUM_STATES = 2 ** (K - 1),
    localparam int SW         = K - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [NUM_STATES-1:0] dec_bits,
    input  logic [SW-1:0]         best_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    input  logic                  flush,
    output logic                  flush_done
);

    localparam int PW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
    localparam int CW = $clog2(TB_DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(TB_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(TB_DEPTH);

    localparam logic [1:0] S_ACCEPT = 2'd0;
    localparam logic [1:0] S_TRACE  = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    logic [1:0]            state;
    logic [NUM_STATES-1:0] mem [TB_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         tb_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         remaining;
    logic [SW-1:0]         tb_state;

    logic                  accept;
    logic [PW-1:0]         wr_ptr_next;
    logic [PW-1:0]         tb_ptr_prev;
    logic                  trace_bit;
    logic [SW-1:0]         pred_state;
    logic [CW-1:0]         count_dec;

    assign dec_ready   = (state == S_ACCEPT);
    assign out_valid   = (state == S_EMIT);
    assign accept      = dec_ready && dec_valid;
    assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    assign tb_ptr_prev = (tb_ptr == '0) ? LAST_PTR : tb_ptr - PW'(1);
    assign trace_bit   = mem[tb_ptr][tb_state];
    assign pred_state  = {tb_state[SW-2:0], trace_bit};
    assign count_dec   = count - CW'(1);

`ifdef SURV_FLUSH_EN
    logic          flush_active;
    logic [SW-1:0] last_best;
    logic [PW-1:0] newest_ptr;

    assign newest_ptr = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PW'(1);
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign flush_done   = 1'b0;
`endif

    // Decision column storage: one column written per accepted handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TB_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= dec_bits;
        end
    end

    // Accept / traceback / emit sequencing and buffer bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_ACCEPT;
            wr_ptr    <= '0;
            tb_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            tb_state  <= '0;
            out_bit   <= 1'b0;
`ifdef SURV_FLUSH_EN
            flush_active <= 1'b0;
            last_best    <= '0;
            flush_done   <= 1'b0;
`endif
        end else begin
`ifdef SURV_FLUSH_EN
            flush_done <= 1'b0;
`endif
            case (state)
                S_ACCEPT: begin
                    if (dec_valid) begin
                        wr_ptr <= wr_ptr_next;
                        count  <= count + CW'(1);
`ifdef SURV_FLUSH_EN
                        last_best <= best_state;
`endif
                        if (count + CW'(1) == DEPTH_C) begin
                            tb_ptr    <= wr_ptr;
                            tb_state  <= best_state;
                            remaining <= DEPTH_C - CW'(1);
                            state     <= S_TRACE;
                        end
                    end
`ifdef SURV_FLUSH_EN
                    else if (flush) begin
                        if (count != '0) begin
                            flush_active <= 1'b1;
                            tb_ptr       <= newest_ptr;
                            tb_state     <= last_best;
                            remaining    <= count_dec;
                            state        <= S_TRACE;
                        end else begin
                            flush_done <= 1'b1;
                        end
                    end
`endif
                end
                S_TRACE: begin
                    if (remaining != '0) begin
                        tb_state  <= pred_state;
                        tb_ptr    <= tb_ptr_prev;
                        remaining <= remaining - CW'(1);
                    end else begin
                        out_bit <= tb_state[SW-1];
                        state   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        count <= count_dec;
`ifdef SURV_FLUSH_EN
                        if (flush_active) begin
                            if (count_dec != '0) begin
                                tb_ptr    <= newest_ptr;
                                tb_state  <= last_best;
                                remaining <= count_dec - CW'(1);
                                state     <= S_TRACE;
                            end else begin
                                flush_done   <= 1'b1;
                                flush_active <= 1'b0;
                                state        <= S_ACCEPT;
                            end
                        end else begin
                            state <= S_ACCEPT;
                        end
`else
                        state <= S_ACCEPT;
`endif
                    end
                end
                default: begin
                    state <= S_ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_survivor_mem.sv
// tb_viterbi_survivor_mem
// Self-checking bench for viterbi_survivor_mem with K=3, TB_DEPTH=4.
// The reference model keeps the undecoded columns in a queue and decodes by
// walking the trellis backwards with plain arithmetic. Flush expectations
// follow SURV_FLUSH_EN.

module tb_viterbi_survivor_mem;

    localparam int K        = 3;
    localparam int TB_DEPTH = 4;
    localparam int NS       = 2 ** (K - 1);
    localparam int SW       = K - 1;

`ifdef SURV_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic          dec_ready;
    logic [NS-1:0] dec_bits;
    logic [SW-1:0] best_state;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic          flush;
    logic          flush_done;

    viterbi_survivor_mem #(
        .K        (K),
        .TB_DEPTH (TB_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_bits   (dec_bits),
        .best_state (best_state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .flush      (flush),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    int test_count = 0;
    int fail_count = 0;

    // reference model: undecoded columns, newest best state, timing phase
    logic [NS-1:0] m_cols[$];
    logic [SW-1:0] m_last_best;
    int            m_phase;
    int            m_wait;
    logic          m_exp_bit;
    bit            m_flushing;
    bit            m_fd;

    logic          out_log[$];
    int            fd_pulses;
    bit            last_acc;

    // encoder path stimulus
    logic [NS-1:0] pbits[16];
    logic [SW-1:0] pstate[16];
    logic          pu[16];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // walk back from the newest column to the oldest, returning the input bit
    function automatic logic modelTrace();
        int s = int'(m_last_best);
        for (int i = m_cols.size() - 1; i >= 1; i--) begin
            s = (s * 2 + int'(m_cols[i][s])) % NS;
        end
        return (s >= NS / 2);
    endfunction

    task automatic modelClear();
        m_cols.delete();
        m_last_best = '0;
        m_phase     = 0;
        m_wait      = 0;
        m_exp_bit   = 1'b0;
        m_flushing  = 1'b0;
        m_fd        = 1'b0;
    endtask

    task automatic checkCycle();
        bit fd_new = 1'b0;
        checkOutput("dec_ready", 32'(dec_ready), 32'(m_phase == 0));
        checkOutput("out_valid", 32'(out_valid), 32'(m_phase == 2));
        checkOutput("flush_done", 32'(flush_done), 32'(m_fd));
        if (m_phase == 2) begin
            checkOutput("out_bit", 32'(out_bit), 32'(m_exp_bit));
        end
        if (flush_done === 1'b1) fd_pulses++;
        last_acc = (dec_valid && dec_ready === 1'b1);
        case (m_phase)
            0: begin
                if (dec_valid) begin
                    m_cols.push_back(dec_bits);
                    m_last_best = best_state;
                    if (m_cols.size() == TB_DEPTH) begin
                        m_exp_bit = modelTrace();
                        m_wait    = TB_DEPTH;
                        m_phase   = 1;
                    end
                end else if (flush && FLUSH_EN) begin
                    if (m_cols.size() > 0) begin
                        m_flushing = 1'b1;
                        m_exp_bit  = modelTrace();
                        m_wait     = m_cols.size();
                        m_phase    = 1;
                    end else begin
                        fd_new = 1'b1;
                    end
                end
            end
            1: begin
                m_wait--;
                if (m_wait == 0) m_phase = 2;
            end
            default: begin
                if (out_ready) begin
                    out_log.push_back(out_bit);
                    void'(m_cols.pop_front());
                    if (m_flushing) begin
                        if (m_cols.size() > 0) begin
                            m_exp_bit = modelTrace();
                            m_wait    = m_cols.size();
                            m_phase   = 1;
                        end else begin
                            fd_new     = 1'b1;
                            m_flushing = 1'b0;
                            m_phase    = 0;
                        end
                    end else begin
                        m_phase = 0;
                    end
                end
            end
        endcase
        m_fd = fd_new;
    endtask

    task automatic applyStimulus(input logic v, input logic [NS-1:0] bits, input logic [SW-1:0] bs,
                                 input logic ordy, input logic fl);
        dec_valid  = v;
        dec_bits   = bits;
        best_state = bs;
        out_ready  = ordy;
        flush      = fl;
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst        = 1'b1;
        dec_valid  = 1'b0;
        dec_bits   = '0;
        best_state = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_ready", 32'(dec_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        modelClear();
        @(posedge clk);
        #1;
        checkOutput("rst_out_bit", 32'(out_bit), 0);
        checkOutput("rst_flush_done", 32'(flush_done), 0);
    endtask

    // random encoder input with decisions consistent along the true path
    task automatic makePath(input int n);
        int st = 0;
        for (int j = 0; j < n; j++) begin
            int u  = int'($urandom_range(1, 0));
            int ns = u * (NS / 2) + st / 2;
            logic [NS-1:0] b = NS'($urandom);
            b[ns]     = logic'(st % 2);
            pu[j]     = logic'(u);
            pstate[j] = SW'(ns);
            pbits[j]  = b;
            st        = ns;
        end
    endtask

    task automatic sendColumns(input int n);
        int sent = 0;
        int budget = 0;
        while (sent < n && budget < 300) begin
            applyStimulus(1'b1, pbits[sent], pstate[sent], 1'b1, 1'b0);
            if (last_acc) sent++;
            budget++;
        end
        if (sent < n) checkOutput("send_timeout", 32'(sent), 32'(n));
    endtask

    task automatic waitIdle();
        int budget = 0;
        while (dec_ready !== 1'b1 && budget < 50) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            budget++;
        end
        if (dec_ready !== 1'b1) checkOutput("idle_timeout", 32'(dec_ready), 1);
    endtask

    initial begin
        int exp_n;
        int fd_before;

        modelClear();
        fd_pulses = 0;

        // all-zero decisions decode to 0 after TB_DEPTH cycles
        resetDut();
        for (int j = 0; j < TB_DEPTH; j++) applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
        for (int j = 0; j < TB_DEPTH; j++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("zero_valid", 32'(out_valid), 1);
        checkOutput("zero_bit", 32'(out_bit), 0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // u = 1,0,1,1 with explicit decisions, then backpressure
        resetDut();
        applyStimulus(1'b1, 4'b1011, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1101, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0111, 2'b11, 1'b0, 1'b0);
        for (int j = 0; j < TB_DEPTH; j++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("dir_bit", 32'(out_bit), 1);
        for (int j = 0; j < 10; j++) applyStimulus(1'b1, 4'hF, 2'b00, 1'b0, 1'b0);
        checkOutput("bp_valid", 32'(out_valid), 1);
        checkOutput("bp_ready", 32'(dec_ready), 0);
        checkOutput("bp_bit", 32'(out_bit), 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("bp_release_ready", 32'(dec_ready), 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // nine-column stream wraps both pointers; output is the input delayed
        resetDut();
        out_log.delete();
        makePath(9);
        sendColumns(9);
        for (int j = 0; j < 10; j++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("wrap_count", 32'(out_log.size()), 9 - TB_DEPTH + 1);
        for (int j = 0; j < out_log.size() && j < 9; j++) begin
            checkOutput($sformatf("wrap_bit%0d", j), 32'(out_log[j]), 32'(pu[j]));
        end

        // end-of-frame flush after six columns
        resetDut();
        out_log.delete();
        fd_pulses = 0;
        makePath(6);
        sendColumns(6);
        waitIdle();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        for (int j = 0; j < 25; j++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        exp_n = FLUSH_EN ? 6 : 3;
        checkOutput("flush_count", 32'(out_log.size()), 32'(exp_n));
        for (int j = 0; j < out_log.size() && j < 6; j++) begin
            checkOutput($sformatf("flush_bit%0d", j), 32'(out_log[j]), 32'(pu[j]));
        end
        checkOutput("flush_pulses", 32'(fd_pulses), 32'(FLUSH_EN ? 1 : 0));

        // flush on an empty buffer, then flush together with a column
        resetDut();
        fd_before = fd_pulses;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("empty_flush_pulse", 32'(fd_pulses - fd_before), 32'(FLUSH_EN ? 1 : 0));
        applyStimulus(1'b1, 4'h5, 2'b01, 1'b1, 1'b1);
        for (int j = 0; j < 5; j++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // reset in the middle of a traceback
        resetDut();
        makePath(TB_DEPTH);
        sendColumns(TB_DEPTH);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 0);
        checkOutput("midrst_ready", 32'(dec_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        modelClear();
        @(posedge clk);
        #1;
        out_log.delete();
        makePath(TB_DEPTH);
        sendColumns(TB_DEPTH);
        for (int j = 0; j < TB_DEPTH + 2; j++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("midrst_count", 32'(out_log.size()), 1);
        if (out_log.size() > 0) checkOutput("midrst_bit", 32'(out_log[0]), 32'(pu[0]));

        // randomized traffic against the queue model
        resetDut();
        for (int j = 0; j < 1500; j++) begin
            applyStimulus(logic'($urandom_range(1, 0)), NS'($urandom), SW'($urandom),
                          ($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
